// File: rtl/decode_stage_q_if.sv
// rtl/decode_stage_q_if.sv - fetch-side and execute-side handshake bundle for decode_stage_q
interface decode_stage_q_if #(
    parameter int PC_W = 32
);
    logic            if_valid;
    logic            if_ready;
    logic [31:0]     if_instr;
    logic [PC_W-1:0] if_pc;
    logic            id_valid;
    logic            id_ready;
    logic [PC_W-1:0] id_pc;
    logic [3:0]      id_rd;
    logic [3:0]      id_rn;
    logic [3:0]      id_rm;
    logic [3:0]      id_rs;
    logic [3:0]      id_alu_op;
    logic [2:0]      id_shift_op;
    logic [7:0]      id_class;
    logic            id_s;
    logic            id_p;
    logic            id_u;
    logic            id_w;
    logic            id_ttcc;
    logic [23:0]     id_imm24;
    logic            id_cond_pass;
    logic            id_und;

    modport master (
        output if_valid, if_instr, if_pc, id_ready,
        input  if_ready, id_valid, id_pc, id_rd, id_rn, id_rm, id_rs, id_alu_op,
               id_shift_op, id_class, id_s, id_p, id_u, id_w, id_ttcc, id_imm24,
               id_cond_pass, id_und
    );

    modport slave (
        input  if_valid, if_instr, if_pc, id_ready,
        output if_ready, id_valid, id_pc, id_rd, id_rn, id_rm, id_rs, id_alu_op,
               id_shift_op, id_class, id_s, id_p, id_u, id_w, id_ttcc, id_imm24,
               id_cond_pass, id_und
    );
endinterface

// File: rtl/decode_stage_q.sv
// rtl/decode_stage_q.sv - queued, registered ARM-subset decode stage with SWP split
module decode_stage_q #(
    parameter int IQ_DEPTH = 4,
    parameter int PC_W     = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [3:0]                flags,
    output logic [$clog2(IQ_DEPTH):0] iq_count,
    decode_stage_q_if.slave           bus
);
    localparam int AW = $clog2(IQ_DEPTH);
    localparam logic [AW:0] DEPTH_C = AW'(IQ_DEPTH - 1) + 1'b1;

    logic [31:0]     iq_instr [IQ_DEPTH];
    logic [PC_W-1:0] iq_pc    [IQ_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic            swp_phase;

    logic [31:0] h;
    logic        push, pop, load;
    logic        c_bx, c_b, c_bl, c_ls, c_swp, c_dp, cond_ok, und;
    logic [3:0]  opc, alu;
    logic [7:0]  cls;
    logic [2:0]  shop;

    logic            r_valid, r_s, r_p, r_u, r_w, r_ttcc, r_cp, r_und;
    logic [PC_W-1:0] r_pc;
    logic [3:0]      r_rd, r_rn, r_rm, r_rs, r_alu;
    logic [2:0]      r_shop;
    logic [7:0]      r_cls;
    logic [23:0]     r_imm;

    assign h        = iq_instr[rd_ptr];
    assign opc      = h[24:21];
    assign bus.if_ready = (count < DEPTH_C);
    assign push     = bus.if_valid && bus.if_ready;
    assign load     = (count != '0) && (!r_valid || bus.id_ready);
    // the first half of a SWP leaves the word at the head for the store half
    assign pop      = load && !(c_swp && !swp_phase);
    assign iq_count = count;

    always_comb begin
        c_bx  = (h[27:4] == 24'h12FFF1);
        c_b   = (h[27:24] == 4'b1010);
        c_bl  = (h[27:24] == 4'b1011);
        c_ls  = ((h[27:25] == 3'b010) || (h[27:25] == 3'b011 && !h[4])) && !h[22];
        c_swp = (h[27:20] == 8'h10) && (h[11:4] == 8'h09);
        c_dp  = (h[27:26] == 2'b00) && !c_bx && !c_swp;

        case (h[31:28])
            4'h0: cond_ok = flags[2];
            4'h1: cond_ok = !flags[2];
            4'h2: cond_ok = flags[1];
            4'h3: cond_ok = !flags[1];
            4'h4: cond_ok = flags[3];
            4'h5: cond_ok = !flags[3];
            4'h6: cond_ok = flags[0];
            4'h7: cond_ok = !flags[0];
            4'h8: cond_ok = flags[1] && !flags[2];
            4'h9: cond_ok = !flags[1] || flags[2];
            4'hA: cond_ok = (flags[3] == flags[0]);
            4'hB: cond_ok = (flags[3] != flags[0]);
            4'hC: cond_ok = !flags[2] && (flags[3] == flags[0]);
            4'hD: cond_ok = flags[2] || (flags[3] != flags[0]);
            4'hE: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase

        case (opc)
            4'b1000: alu = 4'd0;
            4'b1001: alu = 4'd1;
            4'b1010: alu = 4'd2;
            4'b1011: alu = 4'd4;
            default: alu = opc;
        endcase

        shop = (h[27:25] == 3'b001) ? 3'b111 : {h[6:5], h[4]};

        cls    = 8'h00;
        cls[0] = c_dp;
        cls[1] = c_bx;
        cls[2] = c_b;
        cls[3] = c_bl;
        cls[4] = c_ls && h[20];
        cls[5] = c_ls && !h[20];
        cls[6] = c_swp && !swp_phase;
        cls[7] = c_swp && swp_phase;

        // rd=pc is only legal as the exception-return form MOVS/SUBS pc with rn=lr
        und = c_dp && (((opc[3:2] == 2'b10) && !h[20])
                    || ((h[15:12] == 4'hF)
                        && !(h[20] && h[19:16] == 4'hE && (opc == 4'b1101 || opc == 4'b0010)))
                    || ((h[27:25] == 3'b000) && h[4] && h[7]));
        und = und || (h[31:28] == 4'hF);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            iq_instr[wr_ptr] <= bus.if_instr;
            iq_pc[wr_ptr]    <= bus.if_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0; rd_ptr <= '0; count <= '0; swp_phase <= 1'b0;
            r_valid <= 1'b0; r_pc <= '0; r_rd <= '0; r_rn <= '0; r_rm <= '0; r_rs <= '0;
            r_alu <= '0; r_shop <= '0; r_cls <= '0; r_s <= 1'b0; r_p <= 1'b0;
            r_u <= 1'b0; r_w <= 1'b0; r_ttcc <= 1'b0; r_imm <= '0; r_cp <= 1'b0; r_und <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0; rd_ptr <= '0; count <= '0; swp_phase <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (load) begin
                swp_phase <= c_swp && !swp_phase;
                r_valid <= 1'b1;
                r_pc    <= iq_pc[rd_ptr];
                r_rd    <= h[15:12];
                r_rn    <= h[19:16];
                r_rm    <= h[3:0];
                r_rs    <= h[11:8];
                r_alu   <= alu;
                r_shop  <= shop;
                r_cls   <= cls;
                r_s     <= h[20];
                r_p     <= h[24];
                r_u     <= h[23];
                r_w     <= h[21];
                r_ttcc  <= (opc[3:2] == 2'b10);
                r_imm   <= h[23:0];
                r_cp    <= cond_ok;
                r_und   <= und;
            end else if (bus.id_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.id_valid     = r_valid;
    assign bus.id_pc        = r_pc;
    assign bus.id_rd        = r_rd;
    assign bus.id_rn        = r_rn;
    assign bus.id_rm        = r_rm;
    assign bus.id_rs        = r_rs;
    assign bus.id_alu_op    = r_alu;
    assign bus.id_shift_op  = r_shop;
    assign bus.id_class     = r_cls;
    assign bus.id_s         = r_s;
    assign bus.id_p         = r_p;
    assign bus.id_u         = r_u;
    assign bus.id_w         = r_w;
    assign bus.id_ttcc      = r_ttcc;
    assign bus.id_imm24     = r_imm;
    assign bus.id_cond_pass = r_cp;
    assign bus.id_und       = r_und;
endmodule
